// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, host and memory bus bundle for the data-memory arbiter
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_gnt;
    logic              host_rvalid;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_gnt, host_rvalid, host_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    // CPU, host and memory side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_gnt, host_rvalid, host_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority data-memory arbiter with host starvation relief
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] CNT_FORCE = CNT_W'(STARVE_MAX - 1);

    typedef enum logic {
        PRI_CPU    = 1'b0,
        FORCE_HOST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_starve_cnt;
    logic              r_host_rvalid;
    logic [DATA_W-1:0] r_host_rdata;

    logic              w_cpu_gnt;
    logic              w_host_gnt;
    logic              w_cpu_stall;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_cpu_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= PRI_CPU;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Reset suppresses every grant, so no memory write can happen in a reset cycle.
    always_comb begin
        w_next_state = PRI_CPU;
        w_cpu_gnt    = 1'b0;
        w_host_gnt   = 1'b0;
        w_cpu_stall  = 1'b0;
        if (!reset) begin
            case (r_state)
                PRI_CPU: begin
                    if (bus.cpu_req) begin
                        w_cpu_gnt = 1'b1;
                    end else if (bus.host_req) begin
                        w_host_gnt = 1'b1;
                    end
                    if (bus.host_req && !w_host_gnt && r_starve_cnt == CNT_FORCE) begin
                        w_next_state = FORCE_HOST;
                    end
                end
                FORCE_HOST: begin
                    if (bus.host_req) begin
                        w_host_gnt  = 1'b1;
                        w_cpu_stall = bus.cpu_req;
                    end else begin
                        w_cpu_gnt = bus.cpu_req;
                    end
                end
                default: w_next_state = PRI_CPU;
            endcase
        end
    end

    always_comb begin
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_wdata = '0;
        w_cpu_rdata = '0;
        if (w_cpu_gnt) begin
            w_mem_we    = bus.cpu_we;
            w_mem_addr  = bus.cpu_addr;
            w_mem_wdata = bus.cpu_wdata;
            w_cpu_rdata = bus.mem_rdata;
        end else if (w_host_gnt) begin
            w_mem_we    = bus.host_we;
            w_mem_addr  = bus.host_addr;
            w_mem_wdata = bus.host_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || w_host_gnt) begin
            r_starve_cnt <= '0;
        end else if (bus.host_req && r_starve_cnt != CNT_MAX) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
        end else begin
            r_host_rvalid <= w_host_gnt && !bus.host_we;
            if (w_host_gnt && !bus.host_we) begin
                r_host_rdata <= bus.mem_rdata;
            end
        end
    end

    assign bus.cpu_rdata   = w_cpu_rdata;
    assign bus.cpu_stall   = w_cpu_stall;
    assign bus.host_gnt    = w_host_gnt;
    assign bus.host_rvalid = r_host_rvalid;
    assign bus.host_rdata  = r_host_rdata;
    assign bus.mem_we      = w_mem_we;
    assign bus.mem_addr    = w_mem_addr;
    assign bus.mem_wdata   = w_mem_wdata;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a behavioural model
module tb_dmem_arbiter;
    localparam int STARVE = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .STARVE_MAX(STARVE)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] init_word(input int i);
        return 32'(i) * 32'h9E37_79B9;
    endfunction

    // Word-indexed RAM: asynchronous read, write on the clock edge.
    logic [31:0] ram [256];
    bit ram_init = 1'b0;
    assign bus.mem_rdata = ram[bus.mem_addr[9:2]];
    always @(posedge clk) begin
        if (!ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_init <= 1'b1;
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Behavioural model: expected memory contents, run of consecutive host denials,
    // and whether this cycle is the forced host slot.
    logic [31:0] gold [256];
    bit          gold_init = 1'b0;
    int          m_streak  = 0;
    bit          m_force   = 1'b0;
    bit          m_rvalid  = 1'b0;
    logic [31:0] m_rdata   = '0;
    bit          e_cg, e_hg, e_stall, nf;
    logic        e_we;
    logic [31:0] e_addr, e_wd, e_crd;

    always @(negedge clk) begin
        if (!gold_init) begin
            for (int i = 0; i < 256; i++) gold[i] = init_word(i);
            gold_init = 1'b1;
        end
        e_cg = 1'b0; e_hg = 1'b0; e_stall = 1'b0;
        if (!reset) begin
            if (m_force && bus.host_req) begin
                e_hg    = 1'b1;
                e_stall = bus.cpu_req;
            end else begin
                e_cg = bus.cpu_req;
                e_hg = !m_force && !bus.cpu_req && bus.host_req;
            end
        end
        e_we = 1'b0; e_addr = '0; e_wd = '0; e_crd = '0;
        if (e_cg) begin
            e_we = bus.cpu_we; e_addr = bus.cpu_addr; e_wd = bus.cpu_wdata;
            e_crd = gold[bus.cpu_addr[9:2]];
        end else if (e_hg) begin
            e_we = bus.host_we; e_addr = bus.host_addr; e_wd = bus.host_wdata;
        end
        chk("host_gnt", 32'(bus.host_gnt), 32'(e_hg));
        chk("cpu_stall", 32'(bus.cpu_stall), 32'(e_stall));
        chk("mem_we", 32'(bus.mem_we), 32'(e_we));
        chk("mem_addr", bus.mem_addr, e_addr);
        chk("mem_wdata", bus.mem_wdata, e_wd);
        chk("cpu_rdata", bus.cpu_rdata, e_crd);
        chk("host_rvalid", 32'(bus.host_rvalid), 32'(m_rvalid));
        chk("host_rdata", bus.host_rdata, m_rdata);

        if (reset) begin
            m_rvalid = 1'b0; m_rdata = '0; m_streak = 0; m_force = 1'b0;
        end else begin
            m_rvalid = e_hg && !bus.host_we;
            if (m_rvalid) m_rdata = gold[bus.host_addr[9:2]];
            nf = !m_force && bus.host_req && !e_hg && (m_streak == STARVE - 1);
            if (e_hg) m_streak = 0;
            else if (bus.host_req && m_streak < STARVE) m_streak++;
            m_force = nf;
            if (e_we) gold[e_addr[9:2]] = e_wd;
        end
    end

    task automatic drive(input logic rst, input logic creq, input logic cwe,
                         input logic [31:0] caddr, input logic [31:0] cwd,
                         input logic hreq, input logic hwe,
                         input logic [31:0] haddr, input logic [31:0] hwd);
        @(posedge clk);
        #1;
        reset          = rst;
        bus.cpu_req    = creq;  bus.cpu_we  = cwe;  bus.cpu_addr  = caddr; bus.cpu_wdata  = cwd;
        bus.host_req   = hreq;  bus.host_we = hwe;  bus.host_addr = haddr; bus.host_wdata = hwd;
        @(negedge clk);
    endtask

    // CPU loads and host reads at fixed addresses; the host is denied while cpu_req=1.
    task automatic starve_run(input int n, input logic hreq_last);
        for (int c = 0; c < n; c++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, (c == n - 1) ? hreq_last : 1'b1,
                  1'b0, 32'h88, 32'h0);
        end
    endtask

    logic        creq, cwe, hreq, hwe, h_pend, rst;
    logic [31:0] caddr, cwd, haddr, hwd;
    int          load;

    initial begin
        reset = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h90; bus.cpu_wdata = 32'hBAD0;
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = 32'h94; bus.host_wdata = 32'hBAD1;

        // Reset with both requesters asking to write
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 1'b1, 1'b1, 32'h90, 32'hBAD0, 1'b1, 1'b1, 32'h94, 32'hBAD1);
            chk("rst_mem_we", 32'(bus.mem_we), 32'h0);
            chk("rst_host_gnt", 32'(bus.host_gnt), 32'h0);
            chk("rst_host_rvalid", 32'(bus.host_rvalid), 32'h0);
            chk("rst_host_rdata", bus.host_rdata, 32'h0);
        end

        // Host write then host read of 0x80
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h80, 32'hDEAD);
        chk("hwr_gnt", 32'(bus.host_gnt), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h80, 32'h0);
        chk("hrd_gnt", 32'(bus.host_gnt), 32'h1);
        chk("hrd_rvalid_early", 32'(bus.host_rvalid), 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hrd_rvalid", 32'(bus.host_rvalid), 32'h1);
        chk("hrd_rdata", bus.host_rdata, 32'h0000DEAD);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("hrd_rvalid_pulse", 32'(bus.host_rvalid), 32'h0);

        // Starvation: 8 denials, forced slot at cycle 8, counter fresh afterwards
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        starve_run(8, 1'b1);
        chk("starve_c7_gnt", 32'(bus.host_gnt), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h88, 32'h0);
        chk("force_gnt", 32'(bus.host_gnt), 32'h1);
        chk("force_stall", 32'(bus.cpu_stall), 32'h1);
        starve_run(8, 1'b1);
        chk("after_force_stall", 32'(bus.cpu_stall), 32'h0);
        chk("after_force_gnt", 32'(bus.host_gnt), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h88, 32'h0);
        chk("force2_gnt", 32'(bus.host_gnt), 32'h1);

        // Host drops its request in the forced cycle
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        starve_run(8, 1'b1);
        drive(1'b0, 1'b1, 1'b1, 32'h98, 32'h5A5A, 1'b0, 1'b0, 32'h88, 32'h0);
        chk("drop_gnt", 32'(bus.host_gnt), 32'h0);
        chk("drop_stall", 32'(bus.cpu_stall), 32'h0);
        chk("drop_cpu_we", 32'(bus.mem_we), 32'h1);
        chk("drop_addr", bus.mem_addr, 32'h98);
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h88, 32'h0);
        chk("drop_pri_gnt", 32'(bus.host_gnt), 32'h0);
        chk("drop_pri_stall", 32'(bus.cpu_stall), 32'h0);

        // Simultaneous CPU store and host read of 0x84
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b1, 1'b1, 32'h84, 32'h1234, 1'b1, 1'b0, 32'h84, 32'h0);
        chk("coll_gnt", 32'(bus.host_gnt), 32'h0);
        chk("coll_cpu_addr", bus.mem_addr, 32'h84);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h84, 32'h0);
        chk("coll_host_gnt", 32'(bus.host_gnt), 32'h1);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("coll_rdata", bus.host_rdata, 32'h00001234);

        // Reset lands on the forced cycle; the force is forgotten
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        starve_run(8, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 32'hA0, 32'h7777, 1'b1, 1'b1, 32'h88, 32'h3333);
        chk("rstf_gnt", 32'(bus.host_gnt), 32'h0);
        chk("rstf_stall", 32'(bus.cpu_stall), 32'h0);
        chk("rstf_we", 32'(bus.mem_we), 32'h0);
        starve_run(8, 1'b1);
        chk("rstf_c7_gnt", 32'(bus.host_gnt), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 32'h100, 32'h0, 1'b1, 1'b0, 32'h88, 32'h0);
        chk("rstf_c8_gnt", 32'(bus.host_gnt), 32'h1);

        // Randomized traffic with varying CPU load
        h_pend = 1'b0; hwe = 1'b0; haddr = '0; hwd = '0; load = 0;
        for (int c = 0; c < 4000; c++) begin
            if (c % 250 == 0) load = int'($urandom_range(0, 2));
            case (load)
                2:       creq = 1'b1;
                1:       creq = ($urandom_range(0, 9) != 0);
                default: creq = ($urandom_range(0, 2) == 0);
            endcase
            cwe   = $urandom_range(0, 1) == 1;
            caddr = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
            cwd   = $urandom;
            if (!h_pend && $urandom_range(0, 3) != 0) begin
                h_pend = 1'b1;
                hwe    = $urandom_range(0, 1) == 1;
                haddr  = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
                hwd    = $urandom;
            end
            hreq = h_pend && ($urandom_range(0, 49) != 0);
            rst  = ($urandom_range(0, 199) == 0);
            drive(rst, creq, cwe, caddr, cwd, hreq, hwe, haddr, hwd);
            if (bus.host_gnt) h_pend = 1'b0;
        end

        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
